data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder side of the CPU data-memory bus: a 16×8 synchronous data RAM that answers the `mReadFlag`/`mWriteFlag` requests issued by the CPU core.
- It replaces the purely combinational memory model with a handshaked target: an explicit ready pulse, optional wait states, a clear-on-reset sweep and protocol-error detection.
- It sits between the CPU's data-address/data buses and the rest of the system, on the same clock as the core.

## Interface
Parameters:
- `ADDR_W`, 4: address width; depth = 2^ADDR_W words.
- `DATA_W`, 8: word width.
- `WAIT_CYCLES`, 2: wait states inserted per access. Used only when `DMEM_WAIT_EN` is defined; range 0–15.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mReadFlag` in 1: read request (level).
- `mWriteFlag` in 1: write request (level).
- `dataMemAddrBus` in ADDR_W: access address.
- `dataMemInDataBus` in DATA_W: write data from CPU.
- `dataMemOutDataBus` out DATA_W: read data to CPU.
- `memReady` out 1: one-cycle acknowledge of a completed access.
- `memBusy` out 1: high while INIT, WAIT or ACK is active.
- `memError` out 1: one-cycle pulse on a protocol error.

## Operation
- **States.** INIT, IDLE, WAIT, ACK.
- **Reset.** `reset` low → state INIT, sweep counter 0, `dataMemOutDataBus` = 0, `memReady` = 0, `memError` = 0, `memBusy` = 1, re-arm flag set.
- **INIT.** Writes 0 to address `sweep` and increments `sweep` each cycle, covering 2^ADDR_W cycles (16 by default). After the last address → IDLE. Requests during INIT are ignored; they are not queued.
- **Request sampling in IDLE.** A request is sampled only when re-arm = 1 and (`mReadFlag` | `mWriteFlag`).
  - Address, write data and direction are latched on that edge.
  - Re-arm clears.
  - Re-arm sets again in any cycle in IDLE where both flags are low.
- **Collision.** Both flags high when sampled → `memError` pulses in the next cycle. There is no memory access, `dataMemOutDataBus` holds its value, and the FSM goes to ACK so the CPU is still released.
- **WAIT** (only with `DMEM_WAIT_EN`, and only if `WAIT_CYCLES` > 0). The counter loads `WAIT_CYCLES` − 1 and counts down to 0, then → ACK.
- **ACK.** Lasts exactly one cycle with `memReady` = 1, then → IDLE.
  - Write: the RAM is updated at the edge entering ACK.
  - Read: `dataMemOutDataBus` loads the RAM word at the edge entering ACK and holds until the next completed read or reset.
- **Flags deasserted mid-transaction.** No effect; the latched transaction completes.
- **Reset mid-transaction.** The transaction is aborted, a write that has not yet committed is dropped, and the INIT sweep restarts.
- **Wrap.** Address is used modulo 2^ADDR_W; there is no out-of-range condition.

## Timing
- Request sampled at edge k:
  - Without the macro: `memReady` is high during cycle k+1.
  - With the macro: `memReady` is high during cycle k+1+`WAIT_CYCLES`.
- Read data is valid in the same cycle `memReady` is high.
- **Back-to-back accesses.**
  - Flags must be low for at least one IDLE cycle between transactions.
  - Minimum period without the macro is 3 cycles: sample, ACK, re-arm.
- First request can be accepted 2^ADDR_W cycles after reset release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DMEM_WAIT_EN`.
  - Defined: the WAIT state and wait counter exist, and `WAIT_CYCLES` sets access latency.
  - Undefined: the WAIT state and counter are not built, `WAIT_CYCLES` is ignored, and latency is fixed at one cycle.
  - Defined with `WAIT_CYCLES` = 0: behaviour is cycle-identical to undefined.

## Structure
- **Shared package `dmem_pkg`:**
  - state enum `dmem_state_t` (INIT, IDLE, WAIT, ACK);
  - default `ADDR_W`/`DATA_W` constants;
  - `DMEM_WAIT_MAX` = 15.
- **One sub-module, `dmem_array`:** a 2^ADDR_W × DATA_W single-port synchronous RAM with a write-enable and a registered read port, driven by the FSM.

## Test plan
- **Reset sweep.** Assert `reset` low for 2 cycles, then release, then read addr 0xF → `dataMemOutDataBus` = 0x00. A request at cycle 5 after release produces no `memReady`.
- **Write/read, no macro.** Write 0xA5 to addr 0x3 → `memReady` one cycle after sampling. Then read 0x3 → 0xA5 with `memReady` at k+1.
- **Wait states** (`DMEM_WAIT_EN`, `WAIT_CYCLES` = 3). Read sampled at edge k → `memReady` only in cycle k+4, `memBusy` high for cycles k+1..k+4.
- **Collision.** `mReadFlag` = `mWriteFlag` = 1, addr 0x3, data 0xFF → `memError` and `memReady` pulse. Addr 0x3 still reads 0xA5.
- **Re-arm.** Hold `mReadFlag` high for 6 cycles → exactly one `memReady`. Drop the flag for one cycle, raise it again → second `memReady`.
- **Reset mid-access** (`WAIT_CYCLES` = 3). Write 0x5A to 0x7, assert `reset` during WAIT → after the sweep, addr 0x7 reads 0x00.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W   = 4;
  localparam int unsigned DMEM_DATA_W   = 8;
  localparam int unsigned DMEM_WAIT_MAX = 15;
  localparam int unsigned DMEM_WAIT_CW  = $clog2(DMEM_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StWait,
    StAck
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write enable and a registered, resettable read port.
module dmem_array #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  // Contents are cleared by the owner's init sweep, not by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked CPU data-memory target: clear-on-reset sweep, one-shot ready, collision error.
// Optional wait states are built when DMEM_WAIT_EN is defined.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mReadFlag,
  input  logic              mWriteFlag,
  input  logic [ADDR_W-1:0] dataMemAddrBus,
  input  logic [DATA_W-1:0] dataMemInDataBus,
  output logic [DATA_W-1:0] dataMemOutDataBus,
  output logic              memReady,
  output logic              memBusy,
  output logic              memError
);

  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              rearm_q, rearm_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic              req, collide, sample;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef DMEM_WAIT_EN
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    coll_q, coll_d;
  logic [DMEM_WAIT_CW-1:0] wcnt_q, wcnt_d;
`endif

  always_comb begin
    req       = mReadFlag | mWriteFlag;
    collide   = mReadFlag & mWriteFlag;
    sample    = (state_q == StIdle) && rearm_q && req;
    state_d   = state_q;
    sweep_d   = sweep_q;
    rearm_d   = rearm_q;
    error_d   = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = dataMemAddrBus;
    mem_wdata = dataMemInDataBus;
`ifdef DMEM_WAIT_EN
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    coll_d    = coll_q;
    wcnt_d    = wcnt_q;
`endif

    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_addr  = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + 1'b1;
        if (&sweep_q) state_d = StIdle;
      end
      StIdle: begin
        if (!req) rearm_d = 1'b1;
        if (sample) begin
          rearm_d = 1'b0;
          error_d = collide;
`ifdef DMEM_WAIT_EN
          addr_d  = dataMemAddrBus;
          wdata_d = dataMemInDataBus;
          wr_d    = mWriteFlag;
          coll_d  = collide;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            wcnt_d  = DMEM_WAIT_CW'(WAIT_CYCLES - 1);
          end else begin
            state_d = StAck;
            mem_we  = mWriteFlag & ~collide;
            mem_re  = mReadFlag & ~collide;
          end
`else
          state_d = StAck;
          mem_we  = mWriteFlag & ~collide;
          mem_re  = mReadFlag & ~collide;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      StWait: begin
        if (wcnt_q == '0) begin
          // Commit from the latched request; the live buses may have moved on.
          state_d   = StAck;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_we    = wr_q & ~coll_q;
          mem_re    = ~wr_q & ~coll_q;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
`endif
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
      end
    endcase

    ready_d = (state_d == StAck);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StInit;
      sweep_q <= '0;
      rearm_q <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      error_q <= 1'b0;
`ifdef DMEM_WAIT_EN
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      coll_q  <= 1'b0;
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      rearm_q <= rearm_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      error_q <= error_d;
`ifdef DMEM_WAIT_EN
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      coll_q  <= coll_d;
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  dmem_array #(
    .AddrW(ADDR_W),
    .DataW(DATA_W)
  ) u_array (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(dataMemOutDataBus)
  );

  assign memReady = ready_q;
  assign memBusy  = busy_q;
  assign memError = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned WC = 3;
`ifdef DMEM_WAIT_EN
  localparam int unsigned LAT = WC;
`else
  localparam int unsigned LAT = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] dout;
  logic          ready, busy, error;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [DW-1:0] mem_m [2**AW];
  logic [DW-1:0] dout_m;

  data_mem_responder #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mReadFlag        (rd),
    .mWriteFlag       (wr),
    .dataMemAddrBus   (addr),
    .dataMemInDataBus (wdata),
    .dataMemOutDataBus(dout),
    .memReady         (ready),
    .memBusy          (busy),
    .memError         (error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; leaves the DUT idle and re-armed at a negedge.
  task automatic apply_reset();
    reset = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
    dout_m = '0;
    for (int c = 1; c <= 2**AW; c++) begin
      @(negedge clock);
      check_eq("init_busy", 32'(busy), 32'(c < 2**AW));
      check_eq("init_ready", 32'(ready), 32'd0);
      check_eq("init_dout", 32'(dout), 32'd0);
      // A request pulse during the sweep must be dropped.
      rd = (c == 5);
      addr = 4'hF;
    end
  endtask

  // Called at a negedge with the DUT idle and re-armed; flags held for 'hold' cycles.
  task automatic run_txn(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int unsigned hold);
    int unsigned n;
    logic        coll;
    coll  = r & w;
    n     = ((LAT + 2 > hold) ? LAT + 2 : hold) + 1;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    for (int unsigned c = 1; c <= n; c++) begin
      @(negedge clock);
      if (c == LAT + 1 && !coll) begin
        if (w) mem_m[a] = d;
        else   dout_m = mem_m[a];
      end
      check_eq("ready", 32'(ready), 32'(c == LAT + 1));
      check_eq("busy", 32'(busy), 32'(c <= LAT + 1));
      check_eq("error", 32'(error), 32'(coll && c == 1));
      check_eq("dout", 32'(dout), 32'(dout_m));
      if (c >= hold) begin
        rd = 1'b0;
        wr = 1'b0;
      end else begin
        addr  = AW'($urandom);
        wdata = DW'($urandom);
      end
    end
  endtask

  initial begin
    int unsigned op;
    @(negedge clock);
    apply_reset();

    run_txn(1'b1, 1'b0, 4'hF, 8'h00, 1);
    run_txn(1'b0, 1'b1, 4'h3, 8'hA5, 1);
    run_txn(1'b1, 1'b0, 4'h3, 8'h00, 1);
    run_txn(1'b1, 1'b1, 4'h3, 8'hFF, 1);
    run_txn(1'b1, 1'b0, 4'h3, 8'h00, 1);
    run_txn(1'b1, 1'b0, 4'h3, 8'h00, 6);
    run_txn(1'b1, 1'b0, 4'h3, 8'h00, 2);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      run_txn(op < 4, op >= 4, AW'($urandom), DW'($urandom), $urandom_range(1, 5));
    end

    rd    = 1'b0;
    wr    = 1'b1;
    addr  = 4'h7;
    wdata = 8'h5A;
    @(negedge clock);
    apply_reset();
    run_txn(1'b1, 1'b0, 4'h7, 8'h00, 1);
    run_txn(1'b1, 1'b0, 4'h3, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
